regfile_wr_arbiter: RTL and testbench

//  Round-robin arbiter sharing the register file's single write port (we3/wa3/wd3) among NREQ requesters.

---
 rtl/regfile_wr_arbiter_if.sv | 44 ++++
 rtl/regfile_wr_arbiter.sv | 162 ++++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// Purpose: requester handshake bus plus register-file write port of regfile_wr_arbiter.
// Latency: none, signal bundle only; req_lock exists only when REGFILE_ARB_LOCK_EN is defined.
// Backpressure: per-requester valid/ready; the write port itself is never stalled.
interface regfile_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 3,
    parameter int DW   = 8
);
    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
`ifdef REGFILE_ARB_LOCK_EN
    logic [NREQ-1:0]    req_lock;
`endif
    logic               hold;
    logic               we3;
    logic [AW-1:0]      wa3;
    logic [DW-1:0]      wd3;
    logic [PW-1:0]      gnt_id;
    logic               busy;

    // Arbiter side
    modport slave (
        input  req_valid, req_addr, req_data,
`ifdef REGFILE_ARB_LOCK_EN
        input  req_lock,
`endif
        input  hold,
        output req_ready, we3, wa3, wd3, gnt_id, busy
    );

    // Requester / register-file side
    modport master (
        output req_valid, req_addr, req_data,
`ifdef REGFILE_ARB_LOCK_EN
        output req_lock,
`endif
        output hold,
        input  req_ready, we3, wa3, wd3, gnt_id, busy
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Purpose: round-robin share of the register file write port; optional grant locking under REGFILE_ARB_LOCK_EN.
// Latency: one cycle from transfer (req_valid & req_ready) to we3/wa3/wd3/gnt_id.
// Backpressure: req_ready is one-hot or zero; hold or reset forces it to zero, one transfer per cycle max.
module regfile_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int AW       = 3,
    parameter int DW       = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wr_arbiter_if.slave  bus
);
    localparam int PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || LOCK_MAX < 1) begin : g_bad_cfg
        $error("regfile_wr_arbiter: NREQ must be 2..8 and LOCK_MAX >= 1");
    end

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            we3_q;
    logic [AW-1:0]   wa3_q;
    logic [DW-1:0]   wd3_q;
    logic [PW-1:0]   gnt_q;

    logic            found;
    logic [PW-1:0]   win;
    logic [PW-1:0]   cand;
    logic [PW-1:0]   win_nxt;
    logic [NREQ-1:0] gnt_vec;
    logic            xfer;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            lock_act;

`ifdef REGFILE_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);
    typedef enum logic {ARB, LOCKED} state_t;
    state_t          state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Lock only binds while the owner keeps its request up; a dropped valid re-arbitrates the same cycle.
    assign lock_act = (state_q == LOCKED) && bus.req_valid[owner_q];
`else
    assign lock_act = 1'b0;
`endif

    // Pick the winner: locked owner, otherwise first valid requester scanning up from rr_ptr.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
`ifdef REGFILE_ARB_LOCK_EN
        if (lock_act) begin
            found = 1'b1;
            win   = owner_q;
        end
`endif
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(rr_ptr_q) + k) % NREQ);
            if (!lock_act && !found && bus.req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Grant vector and the winner's write payload.
    always_comb begin
        gnt_vec  = '0;
        sel_addr = '0;
        sel_data = '0;
        if (!rst && !bus.hold && found) begin
            gnt_vec[win] = 1'b1;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                sel_addr = bus.req_addr[i*AW +: AW];
                sel_data = bus.req_data[i*DW +: DW];
            end
        end
    end

    assign xfer    = |gnt_vec;
    assign win_nxt = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);

    // Next-state: pointer advances past the winner unless the grant is held by a lock.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
`ifdef REGFILE_ARB_LOCK_EN
        state_d = lock_act ? LOCKED : ARB;
        owner_d = owner_q;
        cnt_d   = lock_act ? cnt_q : '0;
        if (xfer) begin
            if (lock_act) begin
                if (!bus.req_lock[win] || cnt_q == CW'(LOCK_MAX - 1)) begin
                    state_d  = ARB;
                    cnt_d    = '0;
                    rr_ptr_d = win_nxt;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (bus.req_lock[win] && LOCK_MAX > 1) begin
                state_d = LOCKED;
                owner_d = win;
                cnt_d   = CW'(1);
            end else begin
                rr_ptr_d = win_nxt;
            end
        end
`else
        if (xfer) begin
            rr_ptr_d = win_nxt;
        end
`endif
    end

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
`ifdef REGFILE_ARB_LOCK_EN
            state_q  <= ARB;
            owner_q  <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            rr_ptr_q <= rr_ptr_d;
`ifdef REGFILE_ARB_LOCK_EN
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Registered write port; address/data/id hold their last value when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            we3_q <= 1'b0;
            wa3_q <= '0;
            wd3_q <= '0;
            gnt_q <= '0;
        end else begin
            we3_q <= xfer;
            if (xfer) begin
                wa3_q <= sel_addr;
                wd3_q <= sel_data;
                gnt_q <= win;
            end
        end
    end

    assign bus.req_ready = gnt_vec;
    assign bus.we3       = we3_q;
    assign bus.wa3       = wa3_q;
    assign bus.wd3       = wd3_q;
    assign bus.gnt_id    = gnt_q;
    assign bus.busy      = |bus.req_valid;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Purpose: scoreboard bench for regfile_wr_arbiter (NREQ=4, AW=3, DW=8, LOCK_MAX=4).
// Latency: expects each granted write on we3 exactly one cycle after the grant.
// Backpressure: drives hold and reset to confirm req_ready drops and no write is issued.
module tb_regfile_wr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.NREQ(4), .AW(3), .DW(8)) bus ();

    regfile_wr_arbiter #(.NREQ(4), .AW(3), .DW(8), .LOCK_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0] a;
        logic [7:0] d;
        logic [1:0] id;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] a, input logic [7:0] d);
        bus.req_valid[i]       = v;
        bus.req_addr[i*3 +: 3] = a;
        bus.req_data[i*8 +: 8] = d;
    endtask

    // One cycle: check ready against the expected grant, queue the write, then check the write port.
    task automatic tick(input logic [3:0] exp_rdy);
        wr_t e;
        #1;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) begin
                e.a  = bus.req_addr[i*3 +: 3];
                e.d  = bus.req_data[i*8 +: 8];
                e.id = 2'(i);
                exp_q.push_back(e);
            end
        end
        if (rst) exp_q.delete();
        @(posedge clk);
        #1;
        chk("we3", 32'(bus.we3), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (bus.we3) begin
                chk("wa3", 32'(bus.wa3), 32'(e.a));
                chk("wd3", 32'(bus.wd3), 32'(e.d));
                chk("gnt_id", 32'(bus.gnt_id), 32'(e.id));
            end
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 3'd0, 8'h00);
    endtask

    initial begin
        bus.hold      = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
`ifdef REGFILE_ARB_LOCK_EN
        bus.req_lock  = '0;
`endif
        // Reset with everyone requesting
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 3'(i + 4), 8'(8'hA0 + i));
        tick(4'b0000);
        tick(4'b0000);
        chk("rst_wa3", 32'(bus.wa3), 32'd0);
        chk("rst_wd3", 32'(bus.wd3), 32'd0);
        chk("rst_gnt", 32'(bus.gnt_id), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd1);

        // Single write from requester 0
        rst = 1'b0;
        clear_all();
        set_req(0, 1'b1, 3'd3, 8'h63);
        tick(4'b0001);
        chk("single_wd3", 32'(bus.wd3), 32'h63);
        clear_all();
        tick(4'b0000);
        chk("busy_idle", 32'(bus.busy), 32'd0);

        // Move pointer to 0, then fairness with all four requesting
        set_req(3, 1'b1, 3'd5, 8'h33);
        tick(4'b1000);
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 3'(i), 8'(8'h10 + i));
        for (int c = 0; c < 8; c++) tick(4'(1 << (c % 4)));
        clear_all();
        tick(4'b0000);

        // Same-address collision, pointer at 1: 8'h11 must land before 8'h77
        set_req(0, 1'b1, 3'd1, 8'h01);
        tick(4'b0001);
        clear_all();
        set_req(1, 1'b1, 3'd2, 8'h11);
        set_req(2, 1'b1, 3'd2, 8'h77);
        tick(4'b0010);
        set_req(1, 1'b0, 3'd2, 8'h11);
        tick(4'b0100);
        chk("coll_last_wd3", 32'(bus.wd3), 32'h77);
        clear_all();
        tick(4'b0000);

        // Hold stalls requester 3, release lets it through
        set_req(3, 1'b1, 3'd6, 8'h3C);
        bus.hold = 1'b1;
        tick(4'b0000);
        tick(4'b0000);
        bus.hold = 1'b0;
        tick(4'b1000);

        // Reset right after a transfer: write port cleared, pointer back to 0
        clear_all();
        set_req(1, 1'b1, 3'd7, 8'h5A);
        tick(4'b0010);
        rst = 1'b1;
        tick(4'b0000);
        chk("mid_rst_wa3", 32'(bus.wa3), 32'd0);
        chk("mid_rst_wd3", 32'(bus.wd3), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 3'(7 - i), 8'(8'hC0 + i));
        tick(4'b0001);
        clear_all();
        tick(4'b0000);

`ifdef REGFILE_ARB_LOCK_EN
        // Locked requester 0 gets LOCK_MAX grants, then requester 1, then 0 again
        rst = 1'b1;
        tick(4'b0000);
        rst = 1'b0;
        set_req(0, 1'b1, 3'd4, 8'hE0);
        set_req(1, 1'b1, 3'd5, 8'hE1);
        bus.req_lock = 4'b0001;
        tick(4'b0001);
        tick(4'b0001);
        tick(4'b0001);
        tick(4'b0001);
        tick(4'b0010);
        tick(4'b0001);
        bus.req_lock = '0;
        clear_all();
        tick(4'b0000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
